// File: rtl/tt_um_serial_adder8.sv
// Bit-serial 8-bit adder: one full-adder cell fed LSB-first, result 8 clocks after start.
// No backpressure: loads/start are only honoured in IDLE and are silently ignored while busy.
module tt_um_serial_adder8 (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state;
    logic [2:0] cnt;
    logic [7:0] a_sh;
    logic [7:0] b_sh;
    logic [7:0] s_sh;
    logic       c;
    logic [7:0] r;
    logic       cout;
    logic       ovf;
    logic       done;

    logic load_a, load_b, start, cin;
    logic fa_sum, fa_carry;
    logic unused_pins;

    assign load_a = uio_in[0];
    assign load_b = uio_in[1];
    assign start  = uio_in[2];
    assign cin    = uio_in[3];
    assign unused_pins = &{1'b0, ena, uio_in[7:4]};

    // The single full-adder bit cell the sequencer serves.
    assign fa_sum   = a_sh[0] ^ b_sh[0] ^ c;
    assign fa_carry = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 3'd0;
            a_sh  <= 8'h00;
            b_sh  <= 8'h00;
            s_sh  <= 8'h00;
            c     <= 1'b0;
            r     <= 8'h00;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_a || load_b) begin
                        if (load_a) a_sh <= ui_in;
                        if (load_b) b_sh <= ui_in;
                        done <= 1'b0;
                    end else if (start) begin
                        state <= RUN;
                        cnt   <= 3'd0;
                        c     <= cin;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    a_sh <= {1'b0, a_sh[7:1]};
                    b_sh <= {1'b0, b_sh[7:1]};
                    s_sh <= {fa_sum, s_sh[7:1]};
                    c    <= fa_carry;
                    cnt  <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        // c here is the carry into bit 7, fa_carry the carry out of it.
                        r     <= {fa_sum, s_sh[7:1]};
                        cout  <= fa_carry;
                        ovf   <= c ^ fa_carry;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign uo_out  = r;
    assign uio_out = {ovf, done, (state == RUN), cout, 4'b0000};
    assign uio_oe  = 8'b1111_0000;

endmodule

// File: tb/tb_tt_um_serial_adder8.sv
// Randomised and directed bench for tt_um_serial_adder8 against a word-level reference model.
module tb_tt_um_serial_adder8;

    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       ena;
    logic       clk;
    logic       rst_n;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    tt_um_serial_adder8 dut (
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena),
        .clk    (clk),
        .rst_n  (rst_n)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Word-level reference: an addition is a single arithmetic sum that appears 8 clocks later.
    logic [7:0] m_a, m_b, m_r, m_psum;
    logic       m_cout, m_ovf, m_done, m_busy, m_pcout, m_povf;
    int         m_left;

    function automatic logic [9:0] add_ref(input logic [7:0] x, input logic [7:0] y, input logic ci);
        logic [8:0] t;
        logic       v;
        t = {1'b0, x} + {1'b0, y} + {8'd0, ci};
        v = (x[7] == y[7]) && (t[7] != x[7]);
        return {v, t};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a <= 0; m_b <= 0; m_r <= 0; m_cout <= 0; m_ovf <= 0;
            m_done <= 0; m_busy <= 0; m_left <= 0;
            m_psum <= 0; m_pcout <= 0; m_povf <= 0;
        end else if (!m_busy) begin
            if (uio_in[0] || uio_in[1]) begin
                if (uio_in[0]) m_a <= ui_in;
                if (uio_in[1]) m_b <= ui_in;
                m_done <= 0;
            end else if (uio_in[2]) begin
                m_busy <= 1;
                m_left <= 8;
                m_done <= 0;
                {m_povf, m_pcout, m_psum} <= add_ref(m_a, m_b, uio_in[3]);
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 0;
                m_done <= 1;
                m_r    <= m_psum;
                m_cout <= m_pcout;
                m_ovf  <= m_povf;
                m_a    <= 0;
                m_b    <= 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("uo_out", {24'd0, uo_out}, {24'd0, m_r});
            check("uio_out", {24'd0, uio_out}, {24'd0, m_ovf, m_done, m_busy, m_cout, 4'b0000});
            check("uio_oe", {24'd0, uio_oe}, 32'h0000_00F0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] b);
        ui_in = a; uio_in = 8'h01; tick();
        ui_in = b; uio_in = 8'h02; tick();
        uio_in = 8'h00;
    endtask

    // Starts an addition on current operands and returns edges until done (bounded).
    task automatic start_wait(input logic ci, input bit disturb, output int n);
        uio_in = {4'b0000, ci, 3'b100};
        tick();
        uio_in = 8'h00;
        n = 0;
        while (!uio_out[6] && n < 20) begin
            if (disturb && n == 3) begin
                ui_in = 8'h33; uio_in = 8'h05;
            end else begin
                uio_in = 8'h00;
            end
            tick();
            n++;
        end
        uio_in = 8'h00;
        if (n >= 20) check("done_timeout", 32'(n), 32'd8);
    endtask

    task automatic run_add(input logic [7:0] a, input logic [7:0] b, input logic ci, input bit disturb,
                           input logic [7:0] er, input logic ec, input logic ev);
        int n;
        load(a, b);
        start_wait(ci, disturb, n);
        check("latency", 32'(n), 32'd8);
        check("sum", {24'd0, uo_out}, {24'd0, er});
        check("cout", {31'd0, uio_out[4]}, {31'd0, ec});
        check("ovf", {31'd0, uio_out[7]}, {31'd0, ev});
        check("done", {31'd0, uio_out[6]}, 32'd1);
    endtask

    initial begin
        int n;
        logic [7:0] r8;
        ena = 1; ui_in = 0; uio_in = 0; rst_n = 0;
        tick(); tick();
        chk_en = 1;
        check("reset_uo", {24'd0, uo_out}, 32'd0);
        check("reset_uio", {24'd0, uio_out}, 32'd0);
        rst_n = 1;
        tick();

        run_add(8'h0F, 8'h01, 1'b0, 0, 8'h10, 1'b0, 1'b0);
        run_add(8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1, 1'b0);
        run_add(8'h7F, 8'h01, 1'b0, 0, 8'h80, 1'b0, 1'b1);
        run_add(8'h80, 8'h80, 1'b0, 0, 8'h00, 1'b1, 1'b1);
        run_add(8'hAA, 8'h55, 1'b1, 1, 8'h00, 1'b1, 1'b0);
        tick();
        check("no_restart_busy", {31'd0, uio_out[5]}, 32'd0);

        // Reset in the middle of a run discards the partial result.
        load(8'h12, 8'h34);
        uio_in = 8'h04; tick(); uio_in = 8'h00;
        tick(); tick(); tick(); tick();
        rst_n = 0;
        #1;
        check("midrst_uo", {24'd0, uo_out}, 32'd0);
        check("midrst_busy", {31'd0, uio_out[5]}, 32'd0);
        check("midrst_done", {31'd0, uio_out[6]}, 32'd0);
        tick();
        rst_n = 1;
        tick();
        run_add(8'h02, 8'h03, 1'b0, 0, 8'h05, 1'b0, 1'b0);

        // load_b together with start: load wins, done clears, no run.
        ui_in = 8'h44; uio_in = 8'h06; tick(); uio_in = 8'h00;
        check("lds_busy", {31'd0, uio_out[5]}, 32'd0);
        check("lds_done", {31'd0, uio_out[6]}, 32'd0);
        ui_in = 8'h01; uio_in = 8'h01; tick(); uio_in = 8'h00;
        start_wait(1'b0, 0, n);
        check("lds_sum", {24'd0, uo_out}, 32'h45);

        for (int i = 0; i < 30; i++) begin
            logic [7:0] x, y;
            logic ci;
            logic [9:0] e;
            x = 8'($urandom); y = 8'($urandom); ci = 1'($urandom);
            e = add_ref(x, y, ci);
            run_add(x, y, ci, bit'($urandom_range(0, 1)), e[7:0], e[8], e[9]);
        end

        // Free-running random pin activity, including start held high across runs.
        for (int i = 0; i < 600; i++) begin
            r8 = 8'($urandom);
            r8[0] = ($urandom_range(0, 7) == 0);
            r8[1] = ($urandom_range(0, 7) == 0);
            r8[2] = ($urandom_range(0, 2) != 0);
            uio_in = r8;
            ui_in = 8'($urandom);
            tick();
        end
        uio_in = 8'h00;
        n = 0;
        while (uio_out[5] && n < 20) begin
            tick();
            n++;
        end
        check("drain_busy", {31'd0, uio_out[5]}, 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
